// File: rtl/pixel_pack_writer.sv
// -----------------------------------------------------------------------------
// pixel_pack_writer
//
// Packs a stream of 4-bit pixels into memory rows (DATA_WIDTH/4 pixels per
// row) and writes each full row, or the final partial row of a frame, to SRAM
// using the csb/we/addr handshake shared with the 4-bit pixel reader.
// Pixel i of a frame lands at row base_addr + i/16, bits [4k+3:4k], k = i%16.
//
// Optional feature macro: PIXEL_PACK_BYTE_MASK_EN
//   defined   : partial rows enable only the bytes that hold written nibbles
//   undefined : every write uses an all-ones byte mask
//
// Ports
//   clock          in   single clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   begins a frame (honoured in IDLE only)
//   base_addr      in   first row address, sampled on accepted start
//   pix            in   4-bit pixel
//   pix_valid      in   pixel qualifier
//   pix_ready      out  block can accept a pixel (FILL state)
//   flush          in   end of frame: write any partial row, then finish
//   data_ready_mem in   memory acknowledges the current write
//   csb            out  chip select, active low
//   we             out  write enable, active high
//   addr           out  row address
//   data_in        out  row write data
//   wmask          out  byte write mask
//   busy           out  state is not IDLE
//   done           out  one-cycle pulse at frame end
//   row_count      out  rows written since the last start (saturating)
// -----------------------------------------------------------------------------
module pixel_pack_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [3:0]            pix,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  flush,
  input  logic                  data_ready_mem,
  output logic                  csb,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [NUM_WMASKS-1:0] wmask,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   row_count
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int IW      = $clog2(NIBBLES);
  localparam int CW      = IW + 1;  // count must reach NIBBLES

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]               state;
  logic [NIBBLES-1:0][3:0]  buf_q;
  logic [NIBBLES-1:0][3:0]  buf_next;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_next;
  logic [ADDR_WIDTH-1:0]    ptr;
  logic                     flush_pending;
  logic                     xfer;
  logic                     row_full;
  logic [NUM_WMASKS-1:0]    wmask_next;

  // Handshake outputs are pure decodes of the registered state, so no input
  // reaches them combinationally.
  assign pix_ready = (state == ST_FILL);
  assign busy      = (state != ST_IDLE);
  assign xfer      = pix_valid && pix_ready;

  // Buffer and count as they will be after this cycle's transfer. The row
  // launched into WRITE must include a pixel accepted on the same edge.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned, which would infer a latch.
    buf_next   = buf_q;
    count_next = count;
    if (xfer) begin
      buf_next[count[IW-1:0]] = pix;
      count_next              = count + CW'(1);
    end
  end

  assign row_full = (count_next == CW'(NIBBLES));

`ifdef PIXEL_PACK_BYTE_MASK_EN
  // Byte b holds nibbles 2b and 2b+1; it is enabled once nibble 2b is written.
  always_comb begin
    wmask_next = '0;
    for (int b = 0; b < NUM_WMASKS; b++) begin
      if ((2 * b) < int'(count_next)) wmask_next[b] = 1'b1;
    end
  end
`else
  // Partial rows overwrite the whole memory row; unwritten nibbles are zero.
  assign wmask_next = '1;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      // NOTE: the pixel buffer is a small register array, not a RAM, and is
      // reset so that a frame abandoned by reset can never leak into the next.
      state         <= ST_IDLE;
      buf_q         <= '0;
      count         <= '0;
      ptr           <= '0;
      flush_pending <= 1'b0;
      csb           <= 1'b1;
      we            <= 1'b0;
      addr          <= '0;
      data_in       <= '0;
      wmask         <= '0;
      done          <= 1'b0;
      row_count     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from the values present before this edge.
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            ptr           <= base_addr;
            buf_q         <= '0;
            count         <= '0;
            row_count     <= '0;
            flush_pending <= 1'b0;
            state         <= ST_FILL;
          end
        end

        ST_FILL: begin
          buf_q <= buf_next;
          count <= count_next;
          if (row_full || (flush && (count_next != '0))) begin
            // A flush seen with the 16th pixel still writes the full row
            // first, then ends the frame.
            flush_pending <= flush;
            state         <= ST_WRITE;
            csb           <= 1'b0;
            we            <= 1'b1;
            addr          <= ptr;
            data_in       <= buf_next;
            wmask         <= wmask_next;
          end else if (flush) begin
            // Empty flush: nothing buffered, finish without a write.
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end

        ST_WRITE: begin
          // csb/we/addr/data_in/wmask are held until the acknowledge edge.
          if (data_ready_mem) begin
            ptr           <= ptr + ADDR_WIDTH'(1);  // wraps modulo 2^ADDR_WIDTH
            if (row_count != '1) row_count <= row_count + (ADDR_WIDTH + 1)'(1);
            buf_q         <= '0;
            count         <= '0;
            csb           <= 1'b1;
            we            <= 1'b0;
            flush_pending <= 1'b0;
            if (flush_pending || flush) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FILL;
            end
          end else if (flush) begin
            flush_pending <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
